// File: rtl/yonga_lz4_frame_pkg.sv
// Shared types and constants for the LZ4 frame parser: state encoding,
// error codes, magic bytes and the block-size limit derived from BD.
package yonga_lz4_frame_pkg;

    typedef enum logic [3:0] {
        ST_MAGIC  = 4'd0,
        ST_FLG    = 4'd1,
        ST_BD     = 4'd2,
        ST_OPT    = 4'd3,
        ST_HC     = 4'd4,
        ST_BSIZE  = 4'd5,
        ST_DATA   = 4'd6,
        ST_BCHK   = 4'd7,
        ST_CCHK   = 4'd8,
        ST_SKSIZE = 4'd9,
        ST_SKIP   = 4'd10,
        ST_ERR    = 4'd11
    } state_e;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_MAGIC = 3'd1;
    localparam logic [2:0] ERR_FLG   = 3'd2;
    localparam logic [2:0] ERR_BD    = 3'd3;
    localparam logic [2:0] ERR_RAW   = 3'd4;
    localparam logic [2:0] ERR_BSIZE = 3'd5;

    localparam logic [7:0] MAGIC_STD_B0  = 8'h04;
    localparam logic [3:0] MAGIC_SKIP_HI = 4'h5;
    localparam logic [7:0] MAGIC_STD_B1  = 8'h22;
    localparam logic [7:0] MAGIC_SKIP_B1 = 8'h2A;
    localparam logic [7:0] MAGIC_B2      = 8'h4D;
    localparam logic [7:0] MAGIC_B3      = 8'h18;

    // Largest legal block for a BD block-max id; ids below 4 are rejected earlier
    function automatic logic [31:0] max_block_size(input logic [2:0] bd_id);
        logic [31:0] size;
        case (bd_id)
            3'd4:    size = 32'h0001_0000;
            3'd5:    size = 32'h0004_0000;
            3'd6:    size = 32'h0010_0000;
            3'd7:    size = 32'h0040_0000;
            default: size = 32'h0000_0000;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/yonga_lz4_frame_parser.sv
// LZ4 frame parser: strips frame/block framing and checksums, forwards only
// compressed payload bytes to the decoder FIFO, reports frames and errors.
module yonga_lz4_frame_parser
    import yonga_lz4_frame_pkg::*;
#(
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clear,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              m_wr_en,
    output logic [7:0]        m_data,
    input  logic              m_full,
    output logic              o_in_frame,
    output logic              o_frame_done,
    output logic [FCNT_W-1:0] o_frame_count,
    output logic              o_error,
    output logic [2:0]        o_err_code
);

    state_e             state_q;
    logic [1:0]         idx_q;
    logic               skp_q;
    logic [31:0]        shreg_q;
    logic [31:0]        cnt_q;
    logic               bchk_q;
    logic               csize_q;
    logic               cchk_q;
    logic               dictid_q;
    logic [2:0]         bd_q;
    logic               wr_en_q;
    logic [7:0]         data_q;
    logic               in_frame_q;
    logic               done_q;
    logic [FCNT_W-1:0]  fcnt_q;
    logic               error_q;
    logic [2:0]         code_q;

    logic               accept_s;
    logic [31:0]        shreg_d;
    logic               word_done_s;
    logic               size_zero_s;
    logic [31:0]        max_blk_s;
    logic [31:0]        opt_len_s;
    logic               cnt_last_s;
    logic [7:0]         magic_exp_s;
    logic               magic_ok_s;
    logic               frame_end_s;
    logic [2:0]         err_code_s;

    assign accept_s    = s_valid && s_ready;
    // Little-endian fields: the newest byte lands in the top byte
    assign shreg_d     = {s_data, shreg_q[31:8]};
    assign word_done_s = (idx_q == 2'd3);
    assign size_zero_s = (shreg_d == 32'h0000_0000);
    assign max_blk_s   = max_block_size(bd_q);
    assign opt_len_s   = {28'h000_0000, csize_q, dictid_q, 2'b00};
    assign cnt_last_s  = (cnt_q == 32'h0000_0001);

    assign frame_end_s = ((state_q == ST_BSIZE) && word_done_s && size_zero_s && !cchk_q) ||
                         ((state_q == ST_CCHK) && word_done_s);

    // Input handshake: closed in reset, clear and ERR; DATA paces to one byte per two cycles
    always_comb begin
        s_ready = 1'b0;
        if (!rstn || i_clear) begin
            s_ready = 1'b0;
        end else if (state_q == ST_ERR) begin
            s_ready = 1'b0;
        end else if (state_q == ST_DATA) begin
            s_ready = !m_full && !wr_en_q;
        end else begin
            s_ready = 1'b1;
        end
    end

    // Expected magic byte at the current position of the 4-byte magic word
    always_comb begin
        case (idx_q)
            2'd0:    magic_exp_s = MAGIC_STD_B0;
            2'd1:    magic_exp_s = skp_q ? MAGIC_SKIP_B1 : MAGIC_STD_B1;
            2'd2:    magic_exp_s = MAGIC_B2;
            default: magic_exp_s = MAGIC_B3;
        endcase
        magic_ok_s = (s_data == magic_exp_s) ||
                     ((idx_q == 2'd0) && (s_data[7:4] == MAGIC_SKIP_HI));
    end

    // Validate the byte presented against the field the parser is in
    always_comb begin
        err_code_s = ERR_NONE;
        case (state_q)
            ST_MAGIC: begin
                if (!magic_ok_s) begin
                    err_code_s = ERR_MAGIC;
                end else begin
                    err_code_s = ERR_NONE;
                end
            end
            ST_FLG: begin
                if ((s_data[7:6] != 2'b01) || s_data[1]) begin
                    err_code_s = ERR_FLG;
                end else begin
                    err_code_s = ERR_NONE;
                end
            end
            ST_BD: begin
                if (s_data[7] || !s_data[6] || (s_data[3:0] != 4'h0)) begin
                    err_code_s = ERR_BD;
                end else begin
                    err_code_s = ERR_NONE;
                end
            end
            ST_BSIZE: begin
                if (word_done_s && shreg_d[31]) begin
                    err_code_s = ERR_RAW;
                end else if (word_done_s && (shreg_d > max_blk_s)) begin
                    err_code_s = ERR_BSIZE;
                end else begin
                    err_code_s = ERR_NONE;
                end
            end
            default: err_code_s = ERR_NONE;
        endcase
    end

    // Parser FSM, field counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            state_q    <= ST_MAGIC;
            idx_q      <= 2'd0;
            skp_q      <= 1'b0;
            shreg_q    <= 32'h0000_0000;
            cnt_q      <= 32'h0000_0000;
            bchk_q     <= 1'b0;
            csize_q    <= 1'b0;
            cchk_q     <= 1'b0;
            dictid_q   <= 1'b0;
            bd_q       <= 3'd0;
            wr_en_q    <= 1'b0;
            data_q     <= 8'h00;
            in_frame_q <= 1'b0;
            done_q     <= 1'b0;
            fcnt_q     <= {FCNT_W{1'b0}};
            error_q    <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (accept_s) begin
                shreg_q <= shreg_d;
                if (err_code_s != ERR_NONE) begin
                    state_q    <= ST_ERR;
                    error_q    <= 1'b1;
                    code_q     <= err_code_s;
                    in_frame_q <= 1'b0;
                end else if (frame_end_s) begin
                    state_q    <= ST_MAGIC;
                    idx_q      <= 2'd0;
                    done_q     <= 1'b1;
                    fcnt_q     <= fcnt_q + FCNT_W'(1);
                    in_frame_q <= 1'b0;
                end else begin
                    // 4-byte fields end with idx_q wrapping back to 0
                    case (state_q)
                        ST_MAGIC: begin
                            idx_q <= idx_q + 2'd1;
                            if (idx_q == 2'd0) begin
                                skp_q <= (s_data != MAGIC_STD_B0);
                            end
                            if (word_done_s) begin
                                if (skp_q) begin
                                    state_q <= ST_SKSIZE;
                                end else begin
                                    state_q    <= ST_FLG;
                                    in_frame_q <= 1'b1;
                                end
                            end
                        end
                        ST_FLG: begin
                            bchk_q   <= s_data[4];
                            csize_q  <= s_data[3];
                            cchk_q   <= s_data[2];
                            dictid_q <= s_data[0];
                            state_q  <= ST_BD;
                        end
                        ST_BD: begin
                            bd_q <= s_data[6:4];
                            if (opt_len_s != 32'h0000_0000) begin
                                cnt_q   <= opt_len_s;
                                state_q <= ST_OPT;
                            end else begin
                                state_q <= ST_HC;
                            end
                        end
                        ST_OPT: begin
                            cnt_q <= cnt_q - 32'h0000_0001;
                            if (cnt_last_s) begin
                                state_q <= ST_HC;
                            end
                        end
                        ST_HC: state_q <= ST_BSIZE;
                        ST_BSIZE: begin
                            idx_q <= idx_q + 2'd1;
                            if (word_done_s) begin
                                if (size_zero_s) begin
                                    state_q <= ST_CCHK;
                                end else begin
                                    cnt_q   <= shreg_d;
                                    state_q <= ST_DATA;
                                end
                            end
                        end
                        ST_DATA: begin
                            wr_en_q <= 1'b1;
                            data_q  <= s_data;
                            cnt_q   <= cnt_q - 32'h0000_0001;
                            if (cnt_last_s) begin
                                state_q <= bchk_q ? ST_BCHK : ST_BSIZE;
                            end
                        end
                        ST_BCHK: begin
                            idx_q <= idx_q + 2'd1;
                            if (word_done_s) begin
                                state_q <= ST_BSIZE;
                            end
                        end
                        ST_CCHK: idx_q <= idx_q + 2'd1;
                        ST_SKSIZE: begin
                            idx_q <= idx_q + 2'd1;
                            if (word_done_s) begin
                                if (size_zero_s) begin
                                    state_q <= ST_MAGIC;
                                end else begin
                                    cnt_q   <= shreg_d;
                                    state_q <= ST_SKIP;
                                end
                            end
                        end
                        ST_SKIP: begin
                            cnt_q <= cnt_q - 32'h0000_0001;
                            if (cnt_last_s) begin
                                state_q <= ST_MAGIC;
                            end
                        end
                        ST_ERR:  state_q <= ST_ERR;
                        default: state_q <= ST_ERR;
                    endcase
                end
            end
        end
    end

    assign m_wr_en       = wr_en_q;
    assign m_data        = data_q;
    assign o_in_frame    = in_frame_q;
    assign o_frame_done  = done_q;
    assign o_frame_count = fcnt_q;
    assign o_error       = error_q;
    assign o_err_code    = code_q;

endmodule

// File: tb/tb_yonga_lz4_frame_parser.sv
// Self-checking bench: a positional LZ4 stream model annotates every byte with
// its expected effect, and a per-cycle compare process checks the parser.
module tb_yonga_lz4_frame_parser;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_clear = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       m_wr_en;
    logic [7:0] m_data;
    logic       m_full = 1'b0;
    logic       o_in_frame;
    logic       o_frame_done;
    logic [7:0] o_frame_count;
    logic       o_error;
    logic [2:0] o_err_code;

    yonga_lz4_frame_parser #(.FCNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .i_clear(i_clear),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_wr_en(m_wr_en), .m_data(m_data), .m_full(m_full),
        .o_in_frame(o_in_frame), .o_frame_done(o_frame_done),
        .o_frame_count(o_frame_count), .o_error(o_error), .o_err_code(o_err_code)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    // Annotated global byte stream: one entry per byte ever offered
    logic [7:0] m_byte[$];
    bit         m_pl[$];
    bit         m_end[$];
    bit         m_inf[$];
    logic [2:0] m_errc[$];

    int         nxt_idx = 0;
    logic       e_wr = 1'b0;
    logic [7:0] e_data = 8'h00;
    logic       e_done = 1'b0;
    logic [7:0] e_count = 8'h00;
    logic       e_err = 1'b0;
    logic [2:0] e_code = 3'd0;
    logic       e_inf = 1'b0;
    logic       e_halt = 1'b0;
    logic       e_mdata0 = 1'b1;
    int         wr_cnt = 0;
    int         done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] s[$], input int i);
        if (i < s.size()) return s[i];
        return 8'h00;
    endfunction

    function automatic logic [31:0] le32(input logic [7:0] s[$], input int p);
        return {sb(s, p + 3), sb(s, p + 2), sb(s, p + 1), sb(s, p)};
    endfunction

    task automatic mark_inf(input int from, input int cnt);
        for (int k = 0; k < cnt; k++)
            if (from + k < m_inf.size()) m_inf[from + k] = 1'b1;
    endtask

    task automatic set_err(input int i, input logic [2:0] c);
        if (i < m_errc.size()) begin
            m_errc[i] = c;
            m_inf[i]  = 1'b0;
        end
    endtask

    // Walk a stream by field position and record what each byte must cause
    task automatic model_build(input logic [7:0] s[$]);
        int base, n, p, opt;
        logic [7:0] b;
        logic skp, bchk, cchk;
        logic [31:0] v, mx;
        base = m_byte.size();
        n = s.size();
        foreach (s[k]) begin
            m_byte.push_back(s[k]); m_pl.push_back(1'b0); m_end.push_back(1'b0);
            m_inf.push_back(1'b0); m_errc.push_back(3'd0);
        end
        p = 0;
        while (p < n) begin
            b = s[p];
            if (b == 8'h04) skp = 1'b0;
            else if (b >= 8'h50 && b <= 8'h5F) skp = 1'b1;
            else begin set_err(base + p, 3'd1); return; end
            if (sb(s, p + 1) != (skp ? 8'h2A : 8'h22)) begin set_err(base + p + 1, 3'd1); return; end
            if (sb(s, p + 2) != 8'h4D) begin set_err(base + p + 2, 3'd1); return; end
            if (sb(s, p + 3) != 8'h18) begin set_err(base + p + 3, 3'd1); return; end
            p += 4;
            if (skp) begin
                v = le32(s, p);
                p += 4 + int'(v);
                continue;
            end
            mark_inf(base + p - 1, 1);
            b = sb(s, p);
            if (b[7:6] != 2'b01 || b[1]) begin set_err(base + p, 3'd2); return; end
            bchk = b[4];
            cchk = b[2];
            opt = 8 * int'(b[3]) + 4 * int'(b[0]);
            mark_inf(base + p, 1);
            p++;
            b = sb(s, p);
            if (b[7] || b[3:0] != 4'h0 || b[6:4] < 3'd4) begin set_err(base + p, 3'd3); return; end
            mx = 32'h0001_0000 << (2 * (int'(b[6:4]) - 4));
            mark_inf(base + p, 2 + opt);
            p += 2 + opt;
            forever begin
                v = le32(s, p);
                mark_inf(base + p, 4);
                p += 4;
                if (v == 32'd0) begin
                    if (cchk) begin mark_inf(base + p, 4); p += 4; end
                    m_end[base + p - 1] = 1'b1;
                    m_inf[base + p - 1] = 1'b0;
                    break;
                end
                if (v[31]) begin set_err(base + p - 1, 3'd4); return; end
                if (v > mx) begin set_err(base + p - 1, 3'd5); return; end
                for (int k = 0; k < int'(v); k++)
                    if (p + k < n) begin m_pl[base + p + k] = 1'b1; m_inf[base + p + k] = 1'b1; end
                p += int'(v);
                if (bchk) begin mark_inf(base + p, 4); p += 4; end
            end
        end
    endtask

    // Just before each rising edge: check s_ready, decide acceptance, set next-cycle expectations
    always begin
        bit pl, exp_rdy, acc;
        @(negedge clk);
        #4;
        if (!rstn || i_clear) begin
            if (!rstn) chk("s_ready_in_reset", 32'(s_ready), 32'd0);
            e_wr = 1'b0; e_done = 1'b0; e_count = 8'h00; e_err = 1'b0; e_code = 3'd0;
            e_inf = 1'b0; e_halt = 1'b0; e_mdata0 = 1'b1;
            nxt_idx = m_byte.size();
        end else begin
            pl = (nxt_idx < m_byte.size()) ? m_pl[nxt_idx] : 1'b0;
            exp_rdy = e_halt ? 1'b0 : (pl ? (!m_full && !e_wr) : 1'b1);
            chk("s_ready", 32'(s_ready), 32'(exp_rdy));
            acc = s_valid && exp_rdy;
            e_wr = 1'b0; e_done = 1'b0; e_mdata0 = 1'b0;
            if (acc) begin
                if (m_pl[nxt_idx]) begin e_wr = 1'b1; e_data = m_byte[nxt_idx]; end
                if (m_end[nxt_idx]) begin e_done = 1'b1; e_count = e_count + 8'd1; end
                e_inf = m_inf[nxt_idx];
                if (m_errc[nxt_idx] != 3'd0) begin
                    e_err = 1'b1; e_code = m_errc[nxt_idx]; e_halt = 1'b1; e_inf = 1'b0;
                end
                nxt_idx++;
            end
        end
    end

    // Compare registered outputs against the model every cycle
    always begin
        @(negedge clk);
        chk("m_wr_en", 32'(m_wr_en), 32'(e_wr));
        if (e_wr) chk("m_data", 32'(m_data), 32'(e_data));
        if (e_mdata0) chk("m_data_reset", 32'(m_data), 32'd0);
        chk("o_frame_done", 32'(o_frame_done), 32'(e_done));
        chk("o_frame_count", 32'(o_frame_count), 32'(e_count));
        chk("o_error", 32'(o_error), 32'(e_err));
        chk("o_err_code", 32'(o_err_code), 32'(e_code));
        chk("o_in_frame", 32'(o_in_frame), 32'(e_inf));
        if (m_wr_en) wr_cnt++;
        if (o_frame_done) done_cnt++;
    end

    task automatic run_stream(input logic [7:0] s[$], input bit rand_full, input int stop_rel);
        int budget, stop_abs;
        stop_abs = (stop_rel < 0) ? 32'h7fff_ffff : m_byte.size() + stop_rel;
        model_build(s);
        budget = 3000;
        forever begin
            @(negedge clk);
            if (nxt_idx >= m_byte.size() || e_halt || nxt_idx >= stop_abs || budget == 0) break;
            budget--;
            s_valid = ($urandom_range(0, 4) != 0);
            s_data  = m_byte[nxt_idx];
            m_full  = rand_full ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        chk("stream_budget", 32'(budget == 0), 32'd0);
        s_valid = 1'b0;
        m_full  = 1'b0;
        if (stop_rel < 0) repeat (3) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        i_clear = 1'b1; s_valid = 1'b1; s_data = 8'h04;
        @(negedge clk);
        i_clear = 1'b0; s_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        int w0, d0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_count", 32'(o_frame_count), 32'd0);

        // Plain frame, one 5-byte block, end mark
        w0 = wr_cnt; d0 = done_cnt;
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h40, 8'h70, 8'h5A,
              8'h05, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
              8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(s, 1'b0, -1);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd5);
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t1_count", 32'(o_frame_count), 32'd1);

        // Content size, block and content checksums, two blocks, FIFO backpressure
        w0 = wr_cnt; d0 = done_cnt;
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h5C, 8'h40,
              8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77,
              8'h03, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hE1, 8'hE2, 8'hE3, 8'hE4,
              8'h02, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'hE5, 8'hE6, 8'hE7, 8'hE8,
              8'h00, 8'h00, 8'h00, 8'h00, 8'hC9, 8'hCA, 8'hCB, 8'hCC};
        run_stream(s, 1'b1, -1);
        chk("t2_writes", 32'(wr_cnt - w0), 32'd5);
        chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t2_count", 32'(o_frame_count), 32'd2);

        // Skippable frame followed by a frame with content checksum
        w0 = wr_cnt; d0 = done_cnt;
        s = '{8'h50, 8'h2A, 8'h4D, 8'h18, 8'h03, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC,
              8'h04, 8'h22, 8'h4D, 8'h18, 8'h64, 8'h60, 8'h33,
              8'h02, 8'h00, 8'h00, 8'h00, 8'hC1, 8'hC2,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(s, 1'b0, -1);
        chk("t3_writes", 32'(wr_cnt - w0), 32'd2);
        chk("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t3_count", 32'(o_frame_count), 32'd3);

        // Bad magic, then clear and a good frame
        s = '{8'h05, 8'h22, 8'h4D, 8'h18};
        run_stream(s, 1'b0, -1);
        chk("t4_error", 32'(o_error), 32'd1);
        chk("t4_code", 32'(o_err_code), 32'd1);
        chk("t4_ready", 32'(s_ready), 32'd0);
        do_clear();
        chk("t4_code_cleared", 32'(o_err_code), 32'd0);
        chk("t4_count_cleared", 32'(o_frame_count), 32'd0);
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h40, 8'h70, 8'h5A,
              8'h01, 8'h00, 8'h00, 8'h00, 8'h9E, 8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(s, 1'b0, -1);
        chk("t4_count_after", 32'(o_frame_count), 32'd1);

        // Block one byte over the 64 KiB limit, then raw block flag
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h40, 8'h40, 8'h5A, 8'h01, 8'h00, 8'h01, 8'h00};
        run_stream(s, 1'b0, -1);
        chk("t5_code_size", 32'(o_err_code), 32'd5);
        do_clear();
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h40, 8'h40, 8'h5A, 8'h04, 8'h00, 8'h00, 8'h80};
        run_stream(s, 1'b0, -1);
        chk("t5_code_raw", 32'(o_err_code), 32'd4);
        do_clear();

        // Bad FLG and bad BD
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'hC0};
        run_stream(s, 1'b0, -1);
        chk("t7_code_flg", 32'(o_err_code), 32'd2);
        do_clear();
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h40, 8'h30};
        run_stream(s, 1'b0, -1);
        chk("t8_code_bd", 32'(o_err_code), 32'd3);
        do_clear();

        // Reset in the middle of a payload, then a fresh frame
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h60, 8'h50, 8'h5A, 8'h10, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 16; k++) s.push_back(8'(8'h30 + k));
        for (int k = 0; k < 4; k++) s.push_back(8'h00);
        run_stream(s, 1'b0, 19);
        rstn = 1'b0; s_valid = 1'b1; s_data = 8'hEE;
        repeat (2) @(negedge clk);
        rstn = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_frame_reset", 32'(o_in_frame), 32'd0);
        chk("t6_count_reset", 32'(o_frame_count), 32'd0);
        w0 = wr_cnt;
        s = '{8'h04, 8'h22, 8'h4D, 8'h18, 8'h40, 8'h70, 8'h5A,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h61, 8'h62, 8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(s, 1'b0, -1);
        chk("t6_writes_after", 32'(wr_cnt - w0), 32'd2);
        chk("t6_count_after", 32'(o_frame_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/yonga_lz4_frame_parser.md
# yonga_lz4_frame_parser

Byte-stream LZ4 frame parser sitting directly upstream of the LZ4 decoder core's compressed-data FIFO; fed by the UART RX path or the logic-analyzer write path. Validates and strips the LZ4 frame header, block-size words, block/content checksums and skippable frames, and forwards only compressed block payload bytes to the decoder. Reports frame completion, frame count and a sticky error code to the top-level status register.

## Interface
Parameters:
- FCNT_W, 8, width of frame counter (wraps)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_clear  in  1  sync pulse: abort current parse, clear error/counter, return to MAGIC
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_ready  out  1  byte accepted on s_valid && s_ready
- m_wr_en  out  1  write strobe to decoder compressed FIFO
- m_data  out  8  payload byte, valid with m_wr_en
- m_full  in  1  decoder compressed FIFO full
- o_in_frame  out  1  parser past magic of a frame, not yet finished
- o_frame_done  out  1  one-cycle pulse at end of each LZ4 frame (not skippable frames)
- o_frame_count  out  FCNT_W  completed LZ4 frames, wraps
- o_error  out  1  sticky, set on entering ERR
- o_err_code  out  3  0 none, 1 bad magic, 2 bad FLG, 3 bad BD, 4 raw block unsupported, 5 block size over max

## Operation
- States: MAGIC, FLG, BD, OPT, HC, BSIZE, DATA, BCHK, CCHK, SKSIZE, SKIP, ERR. Each consumes one byte per accept; counters track multi-byte fields; multi-byte fields little-endian via 32-bit shift register.
- MAGIC: byte0 0x04 -> standard; 0x50..0x5F -> skippable; other -> ERR(1). Bytes1..3 must be 22 4D 18 (standard) or 2A 4D 18 (skippable), else ERR(1).
- FLG: bits7:6 must be 01, bit1 must be 0, else ERR(2). Latch BCHK (bit4), CSIZE (bit3), CCHK (bit2), DICTID (bit0).
- BD: bit7 and bits3:0 must be 0, bits6:4 in 4..7, else ERR(3). Max block = 64 KiB << 2*(bd-4).
- OPT: skip 8*CSIZE + 4*DICTID bytes (0 -> straight to HC). HC: one byte discarded, not verified.
- BSIZE: 4 bytes. Value 0 -> CCHK if CCHK flag else end of frame. Bit31 set -> ERR(4). bits30:0 > max -> ERR(5). Else DATA with remaining = size.
- DATA: each accepted byte written out; after last byte -> BCHK (4 bytes discarded) if flag, else BSIZE.
- CCHK: 4 bytes discarded, then end of frame.
- End of frame: o_frame_done pulse, o_frame_count+1, -> MAGIC. Concatenated frames supported.
- SKSIZE: 4-byte N; N=0 -> MAGIC; else SKIP discards N bytes -> MAGIC.
- ERR: s_ready=0, holds until i_clear or reset. No resync.
- i_clear beats s_valid in the same cycle; the byte is not accepted.

## Timing
- Reset/i_clear: state MAGIC; s_ready=0 during reset cycle; m_wr_en, o_in_frame, o_frame_done, o_error=0; o_err_code=0, o_frame_count=0, m_data=0.
- Outside ERR, s_ready=1 except in DATA, where s_ready = !m_full && !m_wr_en (max one payload byte per 2 cycles, prevents overflow from m_full lag).
- Payload latency: accept at cycle t -> m_wr_en and m_data at t+1, registered.
- o_frame_done asserts the cycle after the final frame byte is accepted; o_error/o_err_code the cycle after the offending byte.
- o_in_frame rises after 4th magic byte of a standard frame, falls with o_frame_done.
- Block size 0 with CCHK=0: frame_done after last BSIZE byte, zero m_wr_en.

## Structure
- Package yonga_lz4_frame_pkg: state enum, error-code constants, magic byte constants, max-block-size function of BD[6:4].
- Single module, no sub-module; one shared 32-bit byte-remaining counter reused across OPT/DATA/SKIP.

## Test plan
- Frame 04 22 4D 18 | 40 70 | HC | 05 00 00 00 | 5 payload bytes | 00 00 00 00 -> exactly 5 m_wr_en with matching data, o_frame_done once, count=1.
- FLG=0x5C (BCHK, CSIZE, CCHK), 2 blocks + checksums, m_full toggled randomly -> payload only, in order, no write while m_full, count=1.
- Skippable 50 2A 4D 18 03 00 00 00 AA BB CC then a valid frame -> no writes for skippable, one frame_done.
- Byte0 0x05 -> o_error=1, code=1, s_ready=0; i_clear -> code=0, next valid frame parses.
- BD=0x40, block size 0x00010001 -> ERR code 5; block size 0x80000004 -> ERR code 4.
- rstn low mid-DATA -> all outputs reset values, next frame parsed from MAGIC correctly.
